// File: rtl/jt12_fm_mod.sv
// FM operator modulation sequencer: walks the S1,S3,S2,S4 slot order, keeps per-channel
// operator history and registers the phase-modulation input for the current slot.
module jt12_fm_mod #(
  parameter int NUM_CH = 6,
  parameter int W      = 14,
  parameter int OP_LAT = 1,
  localparam int CW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                rst,
  input  logic                clk,
  input  logic                clk_en,
  input  logic                zero,
  input  logic [2:0]          alg_I,
  input  logic [2:0]          fb_I,
  input  logic signed [W-1:0] op_result,
  output logic [1:0]          cur_op,
  output logic [CW-1:0]       cur_ch,
  output logic signed [W:0]   mod_out,
  output logic [1:0]          mod_op,
  output logic [CW-1:0]       mod_ch,
  output logic                mod_valid
);

  if (OP_LAT < 1 || OP_LAT > NUM_CH - 1) begin : g_lat_check
    $error("jt12_fm_mod: OP_LAT=%0d outside 1..%0d", OP_LAT, NUM_CH - 1);
  end

  logic [1:0]          grp;
  logic [CW-1:0]       ch;
  logic signed [W-1:0] m1  [NUM_CH];
  logic signed [W-1:0] m1p [NUM_CH];
  logic signed [W-1:0] m2  [NUM_CH];
  logic signed [W-1:0] m3  [NUM_CH];
  logic signed [W:0]   mod_nxt;
  logic [1:0]          wb_op;
  logic [CW-1:0]       wb_ch;
  logic                wb_vld;

  function automatic logic signed [W:0] mod_calc(
    input logic [1:0]          op,
    input logic [2:0]          alg,
    input logic [2:0]          fb,
    input logic signed [W-1:0] a1,
    input logic signed [W-1:0] a1p,
    input logic signed [W-1:0] a2,
    input logic signed [W-1:0] a3
  );
    logic signed [W:0] x1, x1p, x2, x3, fsum;
    x1   = {a1[W-1], a1};
    x1p  = {a1p[W-1], a1p};
    x2   = {a2[W-1], a2};
    x3   = {a3[W-1], a3};
    fsum = x1 + x1p;
    mod_calc = '0;
    case (op)
      2'd0: if (fb != 3'd0) mod_calc = fsum >>> (4'd9 - {1'b0, fb});
      2'd1: case (alg)
              3'd0, 3'd3, 3'd4, 3'd5, 3'd6: mod_calc = x1;
              default: mod_calc = '0;
            endcase
      2'd2: case (alg)
              3'd0, 3'd2: mod_calc = x2;
              3'd1:       mod_calc = x1 + x2;
              3'd5:       mod_calc = x1;
              default:    mod_calc = '0;
            endcase
      default: case (alg)
              3'd0, 3'd1, 3'd4: mod_calc = x3;
              3'd2:             mod_calc = x1 + x3;
              3'd3:             mod_calc = x2 + x3;
              3'd5:             mod_calc = x1;
              default:          mod_calc = '0;
            endcase
    endcase
  endfunction

  // Slot counter: group order 0..3 maps to S1,S3,S2,S4, i.e. operator code is grp bit-swapped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grp <= '0;
      ch  <= '0;
    end else if (clk_en) begin
      if (zero) begin
        grp <= '0;
        ch  <= '0;
      end else if (ch == CW'(NUM_CH - 1)) begin
        ch  <= '0;
        grp <= grp + 2'd1;
      end else begin
        ch  <= ch + 1'b1;
      end
    end
  end

  assign cur_op  = {grp[0], grp[1]};
  assign cur_ch  = ch;
  assign mod_nxt = mod_calc(cur_op, alg_I, fb_I, m1[ch], m1p[ch], m2[ch], m3[ch]);

  // Stage p0: registered modulation value with its slot tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mod_out   <= '0;
      mod_op    <= '0;
      mod_ch    <= '0;
      mod_valid <= 1'b0;
    end else if (clk_en) begin
      mod_out   <= mod_nxt;
      mod_op    <= cur_op;
      mod_ch    <= ch;
      mod_valid <= 1'b1;
    end
  end

  // Stage p1..: tag delay line so results land on the slot that produced them
  if (OP_LAT == 1) begin : g_nodly
    assign wb_op  = mod_op;
    assign wb_ch  = mod_ch;
    assign wb_vld = mod_valid;
  end else if (OP_LAT > 1) begin : g_dly
    logic [1:0]    op_p  [OP_LAT-1];
    logic [CW-1:0] ch_p  [OP_LAT-1];
    logic          vld_p [OP_LAT-1];
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int k = 0; k < OP_LAT - 1; k++) begin
          op_p[k]  <= '0;
          ch_p[k]  <= '0;
          vld_p[k] <= 1'b0;
        end
      end else if (clk_en) begin
        op_p[0]  <= mod_op;
        ch_p[0]  <= mod_ch;
        vld_p[0] <= mod_valid;
        for (int k = 1; k < OP_LAT - 1; k++) begin
          op_p[k]  <= op_p[k-1];
          ch_p[k]  <= ch_p[k-1];
          vld_p[k] <= vld_p[k-1];
        end
      end
    end
    assign wb_op  = op_p[OP_LAT-2];
    assign wb_ch  = ch_p[OP_LAT-2];
    assign wb_vld = vld_p[OP_LAT-2];
  end

  // History write-back; reads of the same edge already used the old contents
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        m1[i]  <= '0;
        m1p[i] <= '0;
        m2[i]  <= '0;
        m3[i]  <= '0;
      end
    end else if (clk_en && wb_vld) begin
      case (wb_op)
        2'd0: begin
          m1p[wb_ch] <= m1[wb_ch];
          m1[wb_ch]  <= op_result;
        end
        2'd1:    m2[wb_ch] <= op_result;
        2'd2:    m3[wb_ch] <= op_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jt12_fm_mod.sv
// Bench for jt12_fm_mod: OP_LAT=1 and OP_LAT=3 instances against a slot-level behavioural model.
module tb_jt12_fm_mod;
  localparam int NCH = 6;

  logic clk = 1'b0;
  logic rst, clk_en, zero;
  logic [2:0] alg, fb;
  logic signed [13:0] res1, res3;
  logic [1:0] cop1, mop1, cop3, mop3;
  logic [2:0] cch1, mch1, cch3, mch3;
  logic signed [14:0] mod1, mod3;
  logic mv1, mv3;

  int errors = 0;
  int checks = 0;

  // model state, index 0 = OP_LAT 1, index 1 = OP_LAT 3
  int mcnt [2];
  int h1 [2][NCH];
  int h1p[2][NCH];
  int h2 [2][NCH];
  int h3 [2][NCH];
  int q0[$];
  int q1[$];
  int e_mod[2], e_op[2], e_ch[2];
  bit e_vld[2];
  bit fen[4];
  int fval[4];

  jt12_fm_mod #(.NUM_CH(6), .W(14), .OP_LAT(1)) d1 (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .alg_I(alg), .fb_I(fb),
    .op_result(res1), .cur_op(cop1), .cur_ch(cch1), .mod_out(mod1), .mod_op(mop1),
    .mod_ch(mch1), .mod_valid(mv1));

  jt12_fm_mod #(.NUM_CH(6), .W(14), .OP_LAT(3)) d3 (
    .rst(rst), .clk(clk), .clk_en(clk_en), .zero(zero), .alg_I(alg), .fb_I(fb),
    .op_result(res3), .cur_op(cop3), .cur_ch(cch3), .mod_out(mod3), .mod_op(mop3),
    .mod_ch(mch3), .mod_valid(mv3));

  always #5 clk = ~clk;

  function automatic int grp2op(int g);
    case (g)
      0: return 0;
      1: return 2;
      2: return 1;
      default: return 3;
    endcase
  endfunction

  function automatic int floordiv(int a, int d);
    int qv;
    qv = a / d;
    if ((a % d != 0) && (a < 0)) qv = qv - 1;
    return qv;
  endfunction

  function automatic int ref_mod(int i, int op, int ch, int a, int f);
    int x1, x1p, x2, x3;
    x1 = h1[i][ch]; x1p = h1p[i][ch]; x2 = h2[i][ch]; x3 = h3[i][ch];
    case (op)
      0: return (f == 0) ? 0 : floordiv(x1 + x1p, 1 << (9 - f));
      1: return (a == 0 || a == 3 || a == 4 || a == 5 || a == 6) ? x1 : 0;
      2: begin
        if (a == 0 || a == 2) return x2;
        if (a == 1) return x1 + x2;
        if (a == 5) return x1;
        return 0;
      end
      default: begin
        if (a == 0 || a == 1 || a == 4) return x3;
        if (a == 2) return x1 + x3;
        if (a == 3) return x2 + x3;
        if (a == 5) return x1;
        return 0;
      end
    endcase
  endfunction

  // tag (op*8+ch) of the result consumed at the coming edge, -1 if none
  function automatic int pend(int i);
    if (i == 0) return (q0.size() >= 1) ? q0[q0.size() - 1] : -1;
    return (q1.size() >= 3) ? q1[q1.size() - 3] : -1;
  endfunction

  function automatic logic signed [13:0] resval(int i);
    int t;
    t = pend(i);
    if (t >= 0 && fen[t / 8]) return fval[t / 8][13:0];
    return 14'($urandom_range(0, 16383));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0; e_mod[i] = 0; e_op[i] = 0; e_ch[i] = 0; e_vld[i] = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        h1[i][c] = 0; h1p[i][c] = 0; h2[i][c] = 0; h3[i][c] = 0;
      end
    end
    q0.delete();
    q1.delete();
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int s, op, ch, m, t, r, wo, wc;
      s = mcnt[i]; op = grp2op(s / NCH); ch = s % NCH;
      m = ref_mod(i, op, ch, int'(alg), int'(fb));
      t = pend(i);
      r = (i == 0) ? int'(res1) : int'(res3);
      if (t >= 0) begin
        wo = t / 8; wc = t % 8;
        if (wo == 0) begin h1p[i][wc] = h1[i][wc]; h1[i][wc] = r; end
        else if (wo == 1) h2[i][wc] = r;
        else if (wo == 2) h3[i][wc] = r;
      end
      if (i == 0) begin
        q0.push_back(op * 8 + ch);
        if (q0.size() > 1) void'(q0.pop_front());
      end else begin
        q1.push_back(op * 8 + ch);
        if (q1.size() > 3) void'(q1.pop_front());
      end
      e_mod[i] = m; e_op[i] = op; e_ch[i] = ch; e_vld[i] = 1'b1;
      mcnt[i] = zero ? 0 : (s + 1) % (4 * NCH);
    end
  endtask

  task automatic cyc();
    if (clk_en) model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive();
    alg  = 3'($urandom);
    fb   = 3'($urandom);
    res1 = resval(0);
    res3 = resval(1);
  endtask

  task automatic run_n(int n);
    for (int k = 0; k < n; k++) begin
      drive();
      cyc();
    end
  endtask

  task automatic run_until(int op, int ch);
    int k;
    k = 0;
    while (!(grp2op(mcnt[0] / NCH) == op && mcnt[0] % NCH == ch) && k < 100) begin
      drive();
      cyc();
      k++;
    end
    if (k >= 100) begin
      checks++; errors++;
      $display("FAIL run_until timeout: slot op=%0d ch=%0d never reached", op, ch);
    end
  endtask

  task automatic hw_reset();
    rst = 1'b1; clk_en = 1'b0; zero = 1'b0; alg = '0; fb = '0; res1 = '0; res3 = '0;
    for (int k = 0; k < 4; k++) begin fen[k] = 1'b0; fval[k] = 0; end
    @(posedge clk);
    @(negedge clk);
    model_reset();
    rst = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_reset();
    hw_reset();
    rst = 1'b1; clk_en = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if ({cop1, cch1, mod1, mop1, mch1, mv1} !== '0 || {cop3, cch3, mod3, mop3, mch3, mv3} !== '0) begin
      errors++;
      $display("FAIL reset_state: d1 op=%0d ch=%0d mod=%0d mv=%0b d3 mod=%0d mv=%0b, want all 0",
               cop1, cch1, mod1, mv1, mod3, mv3);
    end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++;
    if (mv1 !== 1'b0 || cch1 !== 3'd0) begin
      errors++;
      $display("FAIL reset_hold_no_en: mv=%0b ch=%0d, want 0 0", mv1, cch1);
    end
    clk_en = 1'b1;
    cyc();
    checks++;
    if (cop1 !== 2'd0 || cch1 !== 3'd1 || mv1 !== 1'b1 || mod1 !== 15'sd0) begin
      errors++;
      $display("FAIL first_edge: cur_op=%0d cur_ch=%0d mv=%0b mod=%0d, want 0 1 1 0",
               cop1, cch1, mv1, mod1);
    end
  endtask

  task automatic test_sequence();
    int s, eo;
    hw_reset();
    for (int k = 1; k <= 24; k++) begin
      drive();
      cyc();
      s = k % 24;
      eo = (s < 6) ? 0 : (s < 12) ? 2 : (s < 18) ? 1 : 3;
      checks++;
      if (int'(cop1) !== eo || int'(cch1) !== s % 6 || int'(cop3) !== eo) begin
        errors++;
        $display("FAIL slot_order[%0d]: got op=%0d ch=%0d, want op=%0d ch=%0d", k, cop1, cch1, eo, s % 6);
      end
    end
    run_until(1, 3);
    zero = 1'b1;
    drive();
    cyc();
    zero = 1'b0;
    checks++;
    if (cop1 !== 2'd0 || cch1 !== 3'd0 || cop3 !== 2'd0 || cch3 !== 3'd0) begin
      errors++;
      $display("FAIL zero_resync: got op=%0d ch=%0d, want 0 0", cop1, cch1);
    end
    clk_en = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive();
      zero = k[0];
      cyc();
      checks++;
      if (cop1 !== 2'd0 || cch1 !== 3'd0 || mop1 !== 2'd1 || mch1 !== 3'd3 ||
          int'(mod1) !== e_mod[0] || int'(mod3) !== e_mod[1]) begin
        errors++;
        $display("FAIL en_low_hold[%0d]: op=%0d ch=%0d mop=%0d mch=%0d mod=%0d, want 0 0 1 3 %0d",
                 k, cop1, cch1, mop1, mch1, mod1, e_mod[0]);
      end
    end
    zero = 1'b0;
    clk_en = 1'b1;
  endtask

  task automatic test_mod_path();
    hw_reset();
    fen[0] = 1'b1; fval[0] = 100;
    fen[1] = 1'b1; fval[1] = -50;
    run_until(2, 2);
    alg = 3'd0; drive(); alg = 3'd0; fb = 3'd0;
    cyc();
    checks++;
    if (mod1 !== 15'sd0) begin
      errors++; $display("FAIL s3_before_s2_write: mod=%0d, want 0", mod1);
    end
    run_until(1, 2);
    drive(); alg = 3'd0;
    cyc();
    checks++;
    if (mod1 !== 15'sd100 || mop1 !== 2'd1 || mch1 !== 3'd2) begin
      errors++; $display("FAIL s2_from_m1: mod=%0d op=%0d ch=%0d, want 100 1 2", mod1, mop1, mch1);
    end
    run_until(2, 2);
    drive(); alg = 3'd0;
    cyc();
    checks++;
    if (mod1 !== -15'sd50) begin
      errors++; $display("FAIL s3_prev_sweep_m2: mod=%0d, want -50", mod1);
    end
  endtask

  task automatic test_alg();
    hw_reset();
    fen[0] = 1'b1; fval[0] = 100;
    fen[2] = 1'b1; fval[2] = -30;
    run_until(3, 0);
    drive(); alg = 3'd2;
    cyc();
    checks++;
    if (mod1 !== 15'sd70) begin
      errors++; $display("FAIL alg2_s4: mod=%0d, want 70", mod1);
    end
    fen[1] = 1'b1; fval[1] = 8191; fval[2] = 8191;
    run_n(24);
    run_until(3, 1);
    drive(); alg = 3'd3;
    cyc();
    checks++;
    if (mod1 !== 15'sd16382) begin
      errors++; $display("FAIL alg3_no_wrap: mod=%0d, want 16382", mod1);
    end
    for (int k = 0; k < 24; k++) begin
      drive(); alg = 3'd7; fb = 3'd0;
      cyc();
      checks++;
      if (mod1 !== 15'sd0 || int'(mod3) !== e_mod[1] || e_mod[1] !== 0) begin
        errors++; $display("FAIL alg7_zero[%0d]: d1=%0d d3=%0d, want 0", k, mod1, mod3);
      end
    end
  endtask

  task automatic test_feedback();
    hw_reset();
    fen[0] = 1'b1; fval[0] = 600;
    run_n(24);
    fval[0] = 1000;
    run_n(24);
    run_until(0, 1);
    drive(); fb = 3'd7; cyc();
    checks++;
    if (mod1 !== 15'sd400) begin errors++; $display("FAIL fb7_pos: mod=%0d, want 400", mod1); end
    drive(); fb = 3'd1; cyc();
    checks++;
    if (mod1 !== 15'sd6) begin errors++; $display("FAIL fb1_pos: mod=%0d, want 6", mod1); end
    drive(); fb = 3'd0; cyc();
    checks++;
    if (mod1 !== 15'sd0) begin errors++; $display("FAIL fb0: mod=%0d, want 0", mod1); end
    run_n(24);
    drive(); fb = 3'd7; cyc();
    checks++;
    if (mod1 !== 15'sd500 || mch1 !== 3'd4) begin
      errors++; $display("FAIL fb_m1p_shift: mod=%0d ch=%0d, want 500 4", mod1, mch1);
    end
    hw_reset();
    fen[0] = 1'b1; fval[0] = -600;
    run_n(24);
    fval[0] = -1000;
    run_n(24);
    run_until(0, 5);
    drive(); fb = 3'd7; cyc();
    checks++;
    if (mod1 !== -15'sd400) begin errors++; $display("FAIL fb7_neg: mod=%0d, want -400", mod1); end
  endtask

  task automatic test_lat3();
    hw_reset();
    for (int e = 1; e <= 15; e++) begin
      drive(); alg = 3'd0;
      res3 = (e == 6) ? 14'sd100 : 14'sd7;
      cyc();
    end
    checks++;
    if (mop3 !== 2'd1 || mch3 !== 3'd2 || mod3 !== 15'sd100) begin
      errors++; $display("FAIL lat3_landing: op=%0d ch=%0d mod=%0d, want 1 2 100", mop3, mch3, mod3);
    end
    hw_reset();
    for (int e = 1; e <= 11; e++) begin
      drive(); alg = 3'd0; fb = 3'd7;
      zero = (e == 6);
      res3 = (e == 8) ? 14'sd321 : 14'sd7;
      cyc();
    end
    zero = 1'b0;
    checks++;
    if (mop3 !== 2'd0 || mch3 !== 3'd4 || mod3 !== 15'sd80 || int'(mod3) !== e_mod[1]) begin
      errors++; $display("FAIL zero_inflight: op=%0d ch=%0d mod=%0d, want 0 4 80", mop3, mch3, mod3);
    end
    run_n(7);
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({cop1, cch1, mod1, mop1, mch1, mv1} !== '0 || {cop3, cch3, mod3, mop3, mch3, mv3} !== '0) begin
      errors++; $display("FAIL async_reset: d1 ch=%0d mod=%0d mv=%0b d3 mod=%0d, want 0", cch1, mod1, mv1, mod3);
    end
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(); fb = 3'd7; cyc();
    checks++;
    if (mod1 !== 15'sd0 || mod3 !== 15'sd0) begin
      errors++; $display("FAIL reset_clears_m1: d1=%0d d3=%0d, want 0", mod1, mod3);
    end
    run_until(2, 0);
    drive(); alg = 3'd0; cyc();
    checks++;
    if (mod1 !== 15'sd0 || mod3 !== 15'sd0) begin
      errors++; $display("FAIL reset_clears_m2: d1=%0d d3=%0d, want 0", mod1, mod3);
    end
  endtask

  task automatic test_random();
    hw_reset();
    for (int k = 0; k < 400; k++) begin
      drive();
      clk_en = ($urandom_range(0, 4) != 0);
      zero = ($urandom_range(0, 39) == 0);
      cyc();
      checks++;
      if (int'(mod1) !== e_mod[0] || int'(mop1) !== e_op[0] || int'(mch1) !== e_ch[0] ||
          mv1 !== e_vld[0] || int'(cop1) !== grp2op(mcnt[0] / NCH) || int'(cch1) !== mcnt[0] % NCH) begin
        errors++;
        $display("FAIL rand_lat1[%0d]: mod=%0d op=%0d ch=%0d, want %0d %0d %0d",
                 k, mod1, mop1, mch1, e_mod[0], e_op[0], e_ch[0]);
      end
      checks++;
      if (int'(mod3) !== e_mod[1] || int'(mop3) !== e_op[1] || int'(mch3) !== e_ch[1] ||
          mv3 !== e_vld[1] || int'(cop3) !== grp2op(mcnt[1] / NCH) || int'(cch3) !== mcnt[1] % NCH) begin
        errors++;
        $display("FAIL rand_lat3[%0d]: mod=%0d op=%0d ch=%0d, want %0d %0d %0d",
                 k, mod3, mop3, mch3, e_mod[1], e_op[1], e_ch[1]);
      end
    end
    zero = 1'b0;
    clk_en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_mod_path();
    test_alg();
    test_feedback();
    test_lat3();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
